// File: rtl/uart_pattern_gen.sv
// Burst test-data source: increment, decrement, walking-one or LFSR words over valid/ready.
// Define UART_PATTERN_GEN_LFSR_EN to build LFSR mode 3; otherwise mode 3 behaves as increment.
module uart_pattern_gen #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  burst_len,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] pattern_step;
    logic [DATA_W-1:0] seed_eff;
    logic [LEN_W-1:0]  remaining;
    logic [1:0]        mode_q;
    logic              continuous;
    logic              handshake;
    logic              last_beat;

    assign handshake = (state == RUN) && ready;
    assign last_beat = !continuous && (remaining == LEN_W'(1));

`ifdef UART_PATTERN_GEN_LFSR_EN
    logic lfsr_fb;

    generate
        if (DATA_W == 32) begin : g_fb32
            assign lfsr_fb = pattern[31] ^ pattern[21] ^ pattern[1] ^ pattern[0];
        end else if (DATA_W == 16) begin : g_fb16
            assign lfsr_fb = pattern[15] ^ pattern[14] ^ pattern[12] ^ pattern[3];
        end else begin : g_fb8
            assign lfsr_fb = pattern[7] ^ pattern[5] ^ pattern[4] ^ pattern[3];
        end
    endgenerate
`endif

    always_comb begin
        pattern_step = pattern + DATA_W'(1);
        case (mode_q)
            2'd1: pattern_step = pattern - DATA_W'(1);
            2'd2: pattern_step = {pattern[DATA_W-2:0], pattern[DATA_W-1]};
`ifdef UART_PATTERN_GEN_LFSR_EN
            2'd3: pattern_step = {pattern[DATA_W-2:0], lfsr_fb};
`endif
            default: ;
        endcase
    end

    // Walking-one and LFSR would lock up at zero, so a zero seed becomes 1 for them.
    always_comb begin
        seed_eff = seed;
        if (seed == '0) begin
            if (mode == 2'd2)
                seed_eff = DATA_W'(1);
`ifdef UART_PATTERN_GEN_LFSR_EN
            if (mode == 2'd3)
                seed_eff = DATA_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Stop takes priority over the last-beat exit, so an aborted burst never pulses done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (stop)
                    state_next = IDLE;
                else if (handshake && last_beat)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern    <= '0;
            remaining  <= '0;
            mode_q     <= 2'd0;
            continuous <= 1'b0;
        end else if (state == IDLE && start) begin
            pattern    <= seed_eff;
            remaining  <= burst_len;
            mode_q     <= mode;
            continuous <= (burst_len == '0);
        end else if (handshake) begin
            pattern <= pattern_step;
            if (!continuous)
                remaining <= remaining - LEN_W'(1);
        end
    end

    assign data  = pattern;
    assign valid = (state == RUN);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule
